// File: rtl/microwave_pkg.sv
// Shared types and digit limits for the microwave timer display path.
package microwave_pkg;

    localparam int BCD_W = 4;

    localparam logic [BCD_W-1:0] BCD_MAX_ONES = 4'd9;
    localparam logic [BCD_W-1:0] BCD_MAX_TENS = 4'd5;
    localparam logic [BCD_W-1:0] BCD_MAX_MINS = 4'd9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        DONE    = 2'd3
    } timer_state_t;

endpackage

// File: rtl/timer_bcd_dec.sv
// Combinational 3-digit BCD (m:ss) decrement by one second, with a zero-result flag.
// Latency: 0 cycles. Backpressure: none, pure combinational.
// Minutes wrap 0 -> 9 only if asked to decrement 0:00, which the controller never does.
module timer_bcd_dec
    import microwave_pkg::*;
(
    input  logic [BCD_W-1:0] i_ones,
    input  logic [BCD_W-1:0] i_tens,
    input  logic [BCD_W-1:0] i_mins,
    output logic [BCD_W-1:0] o_ones,
    output logic [BCD_W-1:0] o_tens,
    output logic [BCD_W-1:0] o_mins,
    output logic             o_is_zero_next
);

    always_comb begin
        o_ones = i_ones;
        o_tens = i_tens;
        o_mins = i_mins;
        if (i_ones != '0) begin
            o_ones = i_ones - 4'd1;
        end else begin
            o_ones = BCD_MAX_ONES;
            if (i_tens != '0) begin
                o_tens = i_tens - 4'd1;
            end else begin
                o_tens = BCD_MAX_TENS;
                o_mins = (i_mins != '0) ? (i_mins - 4'd1) : BCD_MAX_MINS;
            end
        end
    end

    assign o_is_zero_next = (o_ones == '0) && (o_tens == '0) && (o_mins == '0);

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave countdown controller: keypad entry, 1 Hz BCD countdown, pause/resume, completion pulse.
// Latency: each sampled input event appears on the registered outputs one cycle later.
// Backpressure: none; strobes are dropped in states that do not use them. Optional beep: TIMER_DONE_BEEP_EN.
module microwave_timer_ctrl
    import microwave_pkg::*;
#(
    parameter int BEEP_TICKS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic             key_valid,
    input  logic [BCD_W-1:0] key_digit,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             door_closed,
    output logic [BCD_W-1:0] sec_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] mins,
    output logic             mag_on,
    output logic             done,
    output logic             beep
);

    timer_state_t     r_state;
    logic [BCD_W-1:0] r_ones;
    logic [BCD_W-1:0] r_tens;
    logic [BCD_W-1:0] r_mins;
    logic             r_mag_on;
    logic             r_done;

    logic [BCD_W-1:0] w_dec_ones;
    logic [BCD_W-1:0] w_dec_tens;
    logic [BCD_W-1:0] w_dec_mins;
    logic             w_dec_zero;
    logic             w_time_zero;
    logic             w_key_ok;

    timer_bcd_dec u_dec (
        .i_ones         (r_ones),
        .i_tens         (r_tens),
        .i_mins         (r_mins),
        .o_ones         (w_dec_ones),
        .o_tens         (w_dec_tens),
        .o_mins         (w_dec_mins),
        .o_is_zero_next (w_dec_zero)
    );

    assign w_time_zero = (r_ones == '0) && (r_tens == '0) && (r_mins == '0);
    // Current ones becomes the tens digit after the shift, so it must be a legal tens value.
    assign w_key_ok    = (key_digit <= BCD_MAX_ONES) && (r_ones <= BCD_MAX_TENS);

`ifdef TIMER_DONE_BEEP_EN
    localparam int CNT_W = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;

    logic             r_beep;
    logic [CNT_W-1:0] r_beep_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ones     <= '0;
            r_tens     <= '0;
            r_mins     <= '0;
            r_mag_on   <= 1'b0;
            r_done     <= 1'b0;
`ifdef TIMER_DONE_BEEP_EN
            r_beep     <= 1'b0;
            r_beep_cnt <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (clear) begin
                r_state  <= IDLE;
                r_ones   <= '0;
                r_tens   <= '0;
                r_mins   <= '0;
                r_mag_on <= 1'b0;
`ifdef TIMER_DONE_BEEP_EN
                r_beep   <= 1'b0;
`endif
            end else begin
                case (r_state)
                    IDLE: begin
                        if (!stop) begin
                            if (start) begin
                                if (door_closed && !w_time_zero) begin
                                    r_state  <= RUNNING;
                                    r_mag_on <= 1'b1;
                                end
                            end else if (key_valid && w_key_ok) begin
                                r_mins <= r_tens;
                                r_tens <= r_ones;
                                r_ones <= key_digit;
                            end
                        end
                    end
                    RUNNING: begin
                        if (stop || !door_closed) begin
                            r_state  <= PAUSED;
                            r_mag_on <= 1'b0;
                        end else if (tick_1hz) begin
                            r_ones <= w_dec_ones;
                            r_tens <= w_dec_tens;
                            r_mins <= w_dec_mins;
                            if (w_dec_zero) begin
                                r_state    <= DONE;
                                r_done     <= 1'b1;
                                r_mag_on   <= 1'b0;
`ifdef TIMER_DONE_BEEP_EN
                                r_beep     <= 1'b1;
                                r_beep_cnt <= '0;
`endif
                            end
                        end
                    end
                    PAUSED: begin
                        if (stop) begin
                            r_state <= IDLE;
                            r_ones  <= '0;
                            r_tens  <= '0;
                            r_mins  <= '0;
                        end else if (start && door_closed) begin
                            r_state  <= RUNNING;
                            r_mag_on <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (stop) begin
                            r_state <= IDLE;
`ifdef TIMER_DONE_BEEP_EN
                            r_beep  <= 1'b0;
`endif
                        end else begin
`ifdef TIMER_DONE_BEEP_EN
                            if (tick_1hz) begin
                                if (r_beep_cnt == CNT_W'(BEEP_TICKS - 1)) begin
                                    r_state    <= IDLE;
                                    r_beep     <= 1'b0;
                                    r_beep_cnt <= '0;
                                end else begin
                                    r_beep_cnt <= r_beep_cnt + CNT_W'(1);
                                end
                            end
`else
                            r_state <= IDLE;
`endif
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign sec_ones = r_ones;
    assign sec_tens = r_tens;
    assign mins     = r_mins;
    assign mag_on   = r_mag_on;
    assign done     = r_done;
`ifdef TIMER_DONE_BEEP_EN
    assign beep     = r_beep;
`else
    assign beep     = 1'b0;
`endif

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed bench for microwave_timer_ctrl; expected values are hand-computed per step.
module tb_microwave_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       start;
    logic       stop;
    logic       clear;
    logic       door_closed;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] mins;
    logic       mag_on;
    logic       done;
    logic       beep;

    int n_assert = 0;
    int n_fail   = 0;

    microwave_timer_ctrl #(.BEEP_TICKS(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .door_closed (door_closed),
        .sec_ones    (sec_ones),
        .sec_tens    (sec_tens),
        .mins        (mins),
        .mag_on      (mag_on),
        .done        (done),
        .beep        (beep)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input logic [11:0] exp);
        chk(tag, {mins, sec_tens, sec_ones}, exp);
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        step();
        key_valid = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        tick_1hz    = 1'b0;
        key_valid   = 1'b0;
        key_digit   = 4'd0;
        start       = 1'b0;
        stop        = 1'b0;
        clear       = 1'b0;
        door_closed = 1'b1;
        step();
        step();
        chk_time("reset_time", 12'h000);
        chk("reset_mag", {11'd0, mag_on}, 12'd0);
        chk("reset_done", {11'd0, done}, 12'd0);
        chk("reset_beep", {11'd0, beep}, 12'd0);
        rst = 1'b0;

        // Keypad entry 1,3,0 then a run with borrows.
        key(4'd1);
        chk_time("key_1", 12'h001);
        key(4'd3);
        chk_time("key_13", 12'h013);
        key(4'd0);
        chk_time("key_130", 12'h130);
        pulse_start();
        chk("start_mag", {11'd0, mag_on}, 12'd1);
        chk_time("start_hold", 12'h130);
        ticks(1);
        chk_time("tick_129", 12'h129);
        ticks(30);
        chk_time("tick_059", 12'h059);
        chk("run_mag", {11'd0, mag_on}, 12'd1);

        // Illegal keys.
        pulse_clear();
        chk_time("clear_time", 12'h000);
        chk("clear_mag", {11'd0, mag_on}, 12'd0);
        key(4'd7);
        key(4'd2);
        chk_time("reject_tens", 12'h007);
        key(4'hA);
        chk_time("reject_nonbcd", 12'h007);

        // Run to completion from 0:02; tick coincident with start is not counted.
        pulse_clear();
        key(4'd2);
        start    = 1'b1;
        tick_1hz = 1'b1;
        step();
        start    = 1'b0;
        tick_1hz = 1'b0;
        chk_time("start_tick_ignored", 12'h002);
        ticks(1);
        chk_time("tick_001", 12'h001);
        chk("pre_done", {11'd0, done}, 12'd0);
        ticks(1);
        chk_time("tick_000", 12'h000);
        chk("done_pulse", {11'd0, done}, 12'd1);
        chk("done_mag", {11'd0, mag_on}, 12'd0);
`ifdef TIMER_DONE_BEEP_EN
        chk("beep_on", {11'd0, beep}, 12'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("done_one_cycle", {11'd0, done}, 12'd0);
        chk("done_start_ignored", {11'd0, mag_on}, 12'd0);
        ticks(2);
        chk("beep_after_2", {11'd0, beep}, 12'd1);
        ticks(1);
        chk("beep_after_3", {11'd0, beep}, 12'd0);
        key(4'd5);
        chk_time("idle_after_beep", 12'h005);
`else
        chk("beep_off", {11'd0, beep}, 12'd0);
        key(4'd5);
        chk("done_one_cycle", {11'd0, done}, 12'd0);
        chk_time("key_in_done_ignored", 12'h000);
        key(4'd5);
        chk_time("idle_after_done", 12'h005);
        chk("beep_still_off", {11'd0, beep}, 12'd0);
`endif

        // Door open with coincident tick pauses and holds.
        pulse_clear();
        key(4'd4);
        key(4'd5);
        pulse_start();
        door_closed = 1'b0;
        tick_1hz    = 1'b1;
        step();
        tick_1hz    = 1'b0;
        chk_time("door_hold", 12'h045);
        chk("door_mag", {11'd0, mag_on}, 12'd0);
        door_closed = 1'b1;
        ticks(1);
        chk_time("paused_tick_ignored", 12'h045);
        pulse_start();
        chk("resume_mag", {11'd0, mag_on}, 12'd1);
        ticks(1);
        chk_time("resume_044", 12'h044);

        // Stop pauses, second stop cancels, start at 0:00 ignored.
        pulse_stop();
        chk("stop_mag", {11'd0, mag_on}, 12'd0);
        chk_time("stop_hold", 12'h044);
        pulse_stop();
        chk_time("cancel_zero", 12'h000);
        pulse_start();
        chk("start_zero_mag", {11'd0, mag_on}, 12'd0);

        // Stop with a coincident tick: no decrement.
        key(4'd9);
        pulse_start();
        stop     = 1'b1;
        tick_1hz = 1'b1;
        step();
        stop     = 1'b0;
        tick_1hz = 1'b0;
        chk_time("stop_tick_hold", 12'h009);
        chk("stop_tick_mag", {11'd0, mag_on}, 12'd0);

        // Reset mid-run.
        pulse_clear();
        key(4'd3);
        pulse_start();
        ticks(1);
        chk_time("pre_rst", 12'h002);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_time("rst_time", 12'h000);
        chk("rst_mag", {11'd0, mag_on}, 12'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
